cdb_arbiter: RTL and testbench

Arbitrates functional-unit results onto the common data bus (CDB). It sits between the execution side (ALU reservation-station units, compare unit, load/store buffer) and every CDB consumer (reservation stations, ROB). Each cycle it grants up to `NUM_CDB` of `NUM_REQ` requesters in round-robin order and drives the granted results on registered broadcast slots. A rotating priority pointer guarantees starvation freedom.

---
 rtl/cdb_arbiter.sv | 72 +++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of up to NUM_CDB of NUM_REQ results onto registered CDB slots
// Ports: clk; rst (async, active-low); flush (sync squash, suppresses all grants);
//   req_valid/req_value/req_tag: per-requester pending result (flattened, requester i at slice i);
//   req_grant: combinational accept per requester;
//   cdb_valid/cdb_value/cdb_tag/cdb_src: registered broadcast slots, packed from slot 0.
module cdb_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB*SRC_W-1:0]  cdb_src
);
    logic [SRC_W-1:0]          ptr, ptr_nxt;
    logic [NUM_CDB-1:0]        valid_nxt;
    logic [NUM_CDB*DATA_W-1:0] value_nxt;
    logic [NUM_CDB*TAG_W-1:0]  tag_nxt;
    logic [NUM_CDB*SRC_W-1:0]  src_nxt;

    // Scan from ptr in wrap-around order; the cnt-th valid requester fills slot cnt.
    // Grants are suppressed while in reset or flushing, which also leaves every slot empty.
    always_comb begin
        int idx, cnt;
        req_grant = '0;
        valid_nxt = '0;
        value_nxt = '0;
        tag_nxt   = '0;
        src_nxt   = '0;
        ptr_nxt   = flush ? '0 : ptr;
        idx       = 0;
        cnt       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (rst && !flush && req_valid[idx] && cnt < NUM_CDB) begin
                req_grant[idx]                  = 1'b1;
                valid_nxt[cnt]                  = 1'b1;
                value_nxt[cnt*DATA_W +: DATA_W] = req_value[idx*DATA_W +: DATA_W];
                tag_nxt[cnt*TAG_W +: TAG_W]     = req_tag[idx*TAG_W +: TAG_W];
                src_nxt[cnt*SRC_W +: SRC_W]     = SRC_W'(idx);
                ptr_nxt                         = SRC_W'((idx + 1) % NUM_REQ);
                cnt++;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            cdb_valid <= '0;
            cdb_value <= '0;
            cdb_tag   <= '0;
            cdb_src   <= '0;
        end else begin
            ptr       <= ptr_nxt;
            cdb_valid <= valid_nxt;
            cdb_value <= value_nxt;
            cdb_tag   <= tag_nxt;
            cdb_src   <= src_nxt;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (NUM_REQ=6, NUM_CDB=2)
module tb_cdb_arbiter;
    typedef struct packed {
        logic [1:0]  v;
        logic [63:0] val;
        logic [5:0]  tag;
        logic [5:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  req_valid = '0;
    logic [191:0] req_value;
    logic [17:0] req_tag;
    logic [5:0]  req_grant;
    logic [1:0]  cdb_valid;
    logic [63:0] cdb_value;
    logic [5:0]  cdb_tag;
    logic [5:0]  cdb_src;

    logic [31:0] vals [6];
    logic [2:0]  tags [6];
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_value(req_value), .req_tag(req_tag),
        .req_grant(req_grant),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_value = '0;
        req_tag   = '0;
        for (int i = 0; i < 6; i++) begin
            req_value[i*32 +: 32] = vals[i];
            req_tag[i*3 +: 3]     = tags[i];
        end
    end

    // Expected slot contents for a cycle whose grants, in scan order, are a then b (-1 = none).
    function automatic exp_t mk(int a, int b);
        exp_t e = '0;
        if (a >= 0) begin
            e.v[0] = 1'b1; e.val[31:0] = vals[a]; e.tag[2:0] = tags[a]; e.src[2:0] = 3'(a);
        end
        if (b >= 0) begin
            e.v[1] = 1'b1; e.val[63:32] = vals[b]; e.tag[5:3] = tags[b]; e.src[5:3] = 3'(b);
        end
        return e;
    endfunction

    // Scoreboard: one expected entry per granting cycle, compared just after the edge it lands on.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total += 4;
            if (cdb_valid !== e.v) begin bad++; $display("FAIL sb_valid got=%b want=%b", cdb_valid, e.v); end
            if (cdb_value !== e.val) begin bad++; $display("FAIL sb_value got=%h want=%h", cdb_value, e.val); end
            if (cdb_tag !== e.tag) begin bad++; $display("FAIL sb_tag got=%h want=%h", cdb_tag, e.tag); end
            if (cdb_src !== e.src) begin bad++; $display("FAIL sb_src got=%h want=%h", cdb_src, e.src); end
        end
    end

    task automatic test_reset();
        req_valid = 6'b111111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (req_grant !== 6'b0) begin bad++; $display("FAIL rst_grant got=%b want=0", req_grant); end
        if (cdb_valid !== 2'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", cdb_valid); end
        if (dut.ptr !== 3'd0) begin bad++; $display("FAIL rst_ptr got=%0d want=0", dut.ptr); end
        rst = 1'b1;
        #1;
        total++;
        if (req_grant !== 6'b000011) begin bad++; $display("FAIL rst_rel_grant got=%b want=000011", req_grant); end
        q.push_back(mk(0, 1));
        @(negedge clk);
        total++;
        if (dut.ptr !== 3'd2) begin bad++; $display("FAIL rst_rel_ptr got=%0d want=2", dut.ptr); end
    endtask

    task automatic test_round_robin();
        logic [5:0] want [3] = '{6'b000011, 6'b001100, 6'b110000};
        flush = 1'b1;
        #1;
        total++;
        if (req_grant !== 6'b0) begin bad++; $display("FAIL rr_flush_grant got=%b want=0", req_grant); end
        q.push_back(mk(-1, -1));
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_grant !== want[c]) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", c, req_grant, want[c]); end
            q.push_back(mk(2*c, 2*c+1));
            @(negedge clk);
        end
        total++;
        if (dut.ptr !== 3'd0) begin bad++; $display("FAIL rr_ptr got=%0d want=0", dut.ptr); end
    endtask

    task automatic test_sparse_wrap();
        req_valid = 6'b010000;
        #1;
        total++;
        if (req_grant !== 6'b010000) begin bad++; $display("FAIL sp_pre_grant got=%b want=010000", req_grant); end
        q.push_back(mk(4, -1));
        @(negedge clk);
        total++;
        if (dut.ptr !== 3'd5) begin bad++; $display("FAIL sp_pre_ptr got=%0d want=5", dut.ptr); end
        req_valid = 6'b100010;
        #1;
        total++;
        if (req_grant !== 6'b100010) begin bad++; $display("FAIL sp_grant got=%b want=100010", req_grant); end
        q.push_back(mk(5, 1));
        @(negedge clk);
        total++;
        if (dut.ptr !== 3'd2) begin bad++; $display("FAIL sp_ptr got=%0d want=2", dut.ptr); end
    endtask

    task automatic test_single();
        vals[3] = 32'hDEADBEEF;
        tags[3] = 3'd0;
        req_valid = 6'b001000;
        #1;
        total++;
        if (req_grant !== 6'b001000) begin bad++; $display("FAIL single_grant got=%b want=001000", req_grant); end
        q.push_back(mk(3, -1));
        @(negedge clk);
        total++;
        if (dut.ptr !== 3'd4) begin bad++; $display("FAIL single_ptr got=%0d want=4", dut.ptr); end
    endtask

    task automatic test_flush();
        req_valid = 6'b010101;
        flush = 1'b1;
        #1;
        total++;
        if (req_grant !== 6'b0) begin bad++; $display("FAIL fl_grant got=%b want=0", req_grant); end
        q.push_back(mk(-1, -1));
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (dut.ptr !== 3'd0) begin bad++; $display("FAIL fl_ptr got=%0d want=0", dut.ptr); end
        #1;
        total++;
        if (req_grant !== 6'b000101) begin bad++; $display("FAIL fl_after_grant got=%b want=000101", req_grant); end
        q.push_back(mk(0, 2));
        @(negedge clk);
        total++;
        if (dut.ptr !== 3'd3) begin bad++; $display("FAIL fl_after_ptr got=%0d want=3", dut.ptr); end
    endtask

    task automatic test_async_reset();
        req_valid = 6'b111111;
        #1;
        total++;
        if (req_grant !== 6'b011000) begin bad++; $display("FAIL ar_grant got=%b want=011000", req_grant); end
        q.push_back(mk(3, 4));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total += 4;
        if (cdb_valid !== 2'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", cdb_valid); end
        if (cdb_value !== 64'b0) begin bad++; $display("FAIL ar_value got=%h want=0", cdb_value); end
        if (dut.ptr !== 3'd0) begin bad++; $display("FAIL ar_ptr got=%0d want=0", dut.ptr); end
        if (req_grant !== 6'b0) begin bad++; $display("FAIL ar_grant_rst got=%b want=0", req_grant); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            vals[i] = 32'hA5A5_0000 | 32'(i * 17 + 1);
            tags[i] = 3'(i + 1);
        end
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_single();
        test_flush();
        test_async_reset();
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
